// File: rtl/sprite_cmd_encoder.sv
// sprite_cmd_encoder: buffers sprite-update and frame-swap requests in a FIFO and serialises
// each into 32-bit command words on the shared writedata bus. Owns the ping-pong front_buf bit.
// Build option: define SPRITE_CMD_GAP_EN to insert an idle GAP cycle after every command word.
module sprite_cmd_encoder #(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_swap,
  input  logic [5:0]                  req_component,
  input  logic [4:0]                  req_child,
  input  logic                        req_visible,
  input  logic                        req_flip,
  input  logic [4:0]                  req_pattern,
  input  logic [9:0]                  req_x,
  input  logic [9:0]                  req_y,
  input  logic [9:0]                  req_attr,
  output logic [31:0]                 writedata,
  output logic                        busy,
  output logic                        front_buf,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(FIFO_DEPTH);
  localparam logic [3:0]  ACT_SPRITE = 4'b0001;
  localparam logic [3:0]  ACT_SWAP   = 4'b1111;

  typedef struct packed {
    logic [5:0] component;
    logic [4:0] child;
    logic       visible;
    logic       flip;
    logic [4:0] pattern;
    logic [9:0] x;
    logic [9:0] y;
    logic [9:0] attr;
  } sprite_t;

  typedef struct packed {
    logic    swap;
    sprite_t spr;
  } entry_t;

  typedef enum logic [2:0] {
    StIdle, StVis, StXpos, StYpos, StAttr, StSwap, StGap
  } state_e;

  entry_t        mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   level_q;
  entry_t        wr_entry;
  entry_t        rd_entry;
  logic          push;
  logic          pop;

  state_e        state_q;
  sprite_t       cur_q;
  logic [31:0]   cmd_word;
  state_e        cmd_next;
`ifdef SPRITE_CMD_GAP_EN
  state_e        gap_ret_q;
`endif

  assign wr_entry = {req_swap, req_component, req_child, req_visible, req_flip, req_pattern,
                     req_x, req_y, req_attr};
  assign rd_entry = mem[rd_ptr_q];

  assign req_ready  = (level_q != FULL_LEVEL);
  assign push       = req_valid && req_ready;
  assign pop        = (state_q == StIdle) && (level_q != '0);
  assign fifo_level = level_q;
  assign busy       = (state_q != StIdle) || (level_q != '0);

  // FIFO storage; contents need no reset since the pointers gate every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= wr_entry;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Command word and follow-on state for whichever word the FSM emits next.
  always_comb begin
    cmd_word = '0;
    cmd_next = StIdle;
    case (state_q)
      StVis: begin
        cmd_word = {cur_q.component, cur_q.child, ACT_SPRITE, 3'b001, ~front_buf,
                    cur_q.visible, cur_q.flip, 6'b0, cur_q.pattern};
        cmd_next = StXpos;
      end
      StXpos: begin
        cmd_word = {cur_q.component, cur_q.child, ACT_SPRITE, 3'b010, ~front_buf,
                    3'b0, cur_q.x};
        cmd_next = StYpos;
      end
      StYpos: begin
        cmd_word = {cur_q.component, cur_q.child, ACT_SPRITE, 3'b011, ~front_buf,
                    3'b0, cur_q.y};
        cmd_next = StAttr;
      end
      StAttr: begin
        cmd_word = {cur_q.component, cur_q.child, ACT_SPRITE, 3'b100, ~front_buf,
                    3'b0, cur_q.attr};
        cmd_next = StIdle;
      end
      StSwap: begin
        cmd_word = {11'b0, ACT_SWAP, 3'b000, ~front_buf, 13'b0};
        cmd_next = StIdle;
      end
      default: begin
        cmd_word = '0;
        cmd_next = StIdle;
      end
    endcase
  end

  // Sequencer: pops in IDLE, registers one word per state, flips front_buf with the swap word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      writedata <= '0;
      front_buf <= 1'b0;
      cur_q     <= '0;
`ifdef SPRITE_CMD_GAP_EN
      gap_ret_q <= StIdle;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          writedata <= '0;
          if (pop) begin
            cur_q   <= rd_entry.spr;
            state_q <= rd_entry.swap ? StSwap : StVis;
          end
        end
        StGap: begin
          writedata <= '0;
`ifdef SPRITE_CMD_GAP_EN
          state_q   <= gap_ret_q;
`else
          state_q   <= StIdle;
`endif
        end
        default: begin
          writedata <= cmd_word;
          if (state_q == StSwap) begin
            front_buf <= ~front_buf;
          end
`ifdef SPRITE_CMD_GAP_EN
          gap_ret_q <= cmd_next;
          state_q   <= StGap;
`else
          state_q   <= cmd_next;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_cmd_encoder.sv
// Self-checking bench for sprite_cmd_encoder: directed steps plus randomized traffic, all
// checked every cycle against a queue-based reference model of the request/word stream.
module tb_sprite_cmd_encoder;

  localparam int unsigned DEPTH = 8;
`ifdef SPRITE_CMD_GAP_EN
  localparam bit GAP = 1'b1;
`else
  localparam bit GAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_swap = 1'b0;
  logic [5:0]  req_component = '0;
  logic [4:0]  req_child = '0;
  logic        req_visible = 1'b0;
  logic        req_flip = 1'b0;
  logic [4:0]  req_pattern = '0;
  logic [9:0]  req_x = '0;
  logic [9:0]  req_y = '0;
  logic [9:0]  req_attr = '0;
  logic        req_ready;
  logic [31:0] writedata;
  logic        busy;
  logic        front_buf;
  logic [$clog2(DEPTH):0] fifo_level;

  sprite_cmd_encoder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_swap      (req_swap),
    .req_component (req_component),
    .req_child     (req_child),
    .req_visible   (req_visible),
    .req_flip      (req_flip),
    .req_pattern   (req_pattern),
    .req_x         (req_x),
    .req_y         (req_y),
    .req_attr      (req_attr),
    .writedata     (writedata),
    .busy          (busy),
    .front_buf     (front_buf),
    .fifo_level    (fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          swap;
    int unsigned comp, child, vis, flip, pat, x, y, attr;
  } req_s;

  // Reference model: pending requests, words still to appear on the bus, buffer bit.
  req_s        fifo_m[$];
  int unsigned out_m[$];
  int unsigned level_m = 0;
  bit          front_m = 1'b0;
  int          checks = 0;
  int          errors = 0;
  bit          saw_not_ready = 1'b0;

  function automatic int unsigned cmd(input int unsigned comp, input int unsigned child,
                                      input int unsigned action, input int unsigned typ,
                                      input int unsigned tog, input int unsigned data);
    return comp * 32'd67108864 + child * 32'd2097152 + action * 32'd131072 +
           typ * 32'd16384 + tog * 32'd8192 + data;
  endfunction

  task automatic expand(input req_s r);
    int unsigned tog;
    int unsigned d;
    tog = front_m ? 0 : 1;
    if (r.swap) begin
      out_m.push_back(cmd(0, 0, 15, 0, tog, 0));
      if (GAP) out_m.push_back(0);
    end else begin
      for (int unsigned t = 1; t <= 4; t++) begin
        d = (t == 1) ? r.vis * 4096 + r.flip * 2048 + r.pat :
            (t == 2) ? r.x : (t == 3) ? r.y : r.attr;
        out_m.push_back(cmd(r.comp, r.child, 1, t, tog, d));
        if (GAP) out_m.push_back(0);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input bit s, input int unsigned c, input int unsigned ch,
                         input int unsigned v, input int unsigned f, input int unsigned p,
                         input int unsigned x, input int unsigned y, input int unsigned a);
    req_swap      = s;
    req_component = 6'(c);
    req_child     = 5'(ch);
    req_visible   = 1'(v);
    req_flip      = 1'(f);
    req_pattern   = 5'(p);
    req_x         = 10'(x);
    req_y         = 10'(y);
    req_attr      = 10'(a);
  endtask

  // One clock: advance the model across the edge, then compare every output.
  task automatic cycle();
    bit          push;
    bit          pop;
    req_s        r;
    int unsigned exp_wd;
    push = (req_valid === 1'b1) && (level_m != DEPTH) && (reset === 1'b1);
    pop  = (out_m.size() == 0) && (level_m != 0);
    r.swap = req_swap;   r.comp = req_component; r.child = req_child;
    r.vis  = req_visible; r.flip = req_flip;     r.pat   = req_pattern;
    r.x    = req_x;      r.y    = req_y;         r.attr  = req_attr;
    @(posedge clk);
    exp_wd = 0;
    if (reset !== 1'b1) begin
      fifo_m.delete();
      out_m.delete();
      level_m = 0;
      front_m = 1'b0;
    end else begin
      if (out_m.size() != 0) begin
        exp_wd = out_m.pop_front();
        if (((exp_wd >> 17) & 15) == 15) front_m = ~front_m;
      end
      if (pop) begin
        expand(fifo_m.pop_front());
        level_m--;
      end
      if (push) begin
        fifo_m.push_back(r);
        level_m++;
      end
    end
    #1;
    chk("writedata", writedata, exp_wd);
    chk("front_buf", 32'(front_buf), 32'(front_m));
    chk("fifo_level", 32'(fifo_level), level_m);
    chk("req_ready", 32'(req_ready), (level_m != DEPTH) ? 1 : 0);
    chk("busy", 32'(busy), (out_m.size() != 0 || level_m != 0) ? 1 : 0);
    if (req_ready === 1'b0) saw_not_ready = 1'b1;
  endtask

  task automatic drain();
    req_valid = 1'b0;
    for (int i = 0; i < 300 && (level_m != 0 || out_m.size() != 0); i++) cycle();
    cycle();
  endtask

  initial begin
    logic [31:0] lit [4];
    int          nz;
    int unsigned max_lvl;

    // Reset held low for two cycles.
    reset = 1'b0;
    cycle();
    cycle();
    chk("rst_writedata", writedata, 0);
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_front_buf", 32'(front_buf), 0);
    chk("rst_fifo_level", 32'(fifo_level), 0);
    reset = 1'b1;
    cycle();

    // Single sprite request: idle pop cycle, then the four words.
    set_req(0, 2, 3, 1, 0, 9, 100, 200, 5);
    req_valid = 1'b1;
    cycle();
    req_valid = 1'b0;
    chk("push_level", 32'(fifo_level), 1);
    cycle();
    chk("pop_cycle_idle", writedata, 0);
    lit = '{32'h08627009, 32'h0862A064, 32'h0862E0C8, 32'h08632005};
    nz = 0;
    for (int i = 0; i < (GAP ? 8 : 4); i++) begin
      cycle();
      chk("sprite_word", writedata, GAP ? ((i % 2 != 0) ? 32'h0 : lit[i / 2]) : lit[i]);
      if (writedata != 0) nz++;
    end
    cycle();
    chk("sprite_then_idle", writedata, 0);
    chk("sprite_word_count", nz, 4);
    chk("sprite_done_busy", 32'(busy), 0);

    // Swap request, then a sprite that must target the new back buffer.
    set_req(1, 5, 7, 1, 1, 3, 1, 2, 3);
    req_valid = 1'b1;
    cycle();
    req_valid = 1'b0;
    cycle();
    cycle();
    chk("swap_word", writedata, 32'h001E2000);
    chk("swap_front_buf", 32'(front_buf), 1);
    cycle();
    chk("swap_then_idle", writedata, 0);
    set_req(0, 63, 31, 0, 1, 31, 1023, 512, 777);
    req_valid = 1'b1;
    cycle();
    req_valid = 1'b0;
    nz = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (writedata != 0) begin
        nz++;
        chk("post_swap_toggle", 32'(writedata[13]), 0);
      end
    end
    chk("post_swap_word_count", nz, 4);

    // Overflow: keep pushing while a sequence holds the FSM busy.
    set_req(0, 1, 1, 1, 1, 1, 1, 1, 1);
    req_valid = 1'b1;
    cycle();
    saw_not_ready = 1'b0;
    max_lvl = 0;
    for (int unsigned i = 0; i < DEPTH + 2; i++) begin
      set_req(0, 4, i, i % 2, 0, i, 100 + i, 300 + i, 500 + i);
      req_valid = 1'b1;
      cycle();
      if (32'(fifo_level) > max_lvl) max_lvl = 32'(fifo_level);
    end
    req_valid = 1'b0;
    chk("overflow_ready_dropped", 32'(saw_not_ready), 1);
    chk("overflow_max_level", max_lvl, DEPTH);
    drain();
    chk("overflow_drained_level", 32'(fifo_level), 0);

    // Randomized traffic with occasional swaps.
    for (int i = 0; i < 400; i++) begin
      set_req($urandom_range(0, 7) == 0, $urandom_range(0, 63), $urandom_range(0, 31),
              $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 31),
              $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023));
      req_valid = ($urandom_range(0, 2) != 0);
      cycle();
    end
    drain();

    // Reset asserted mid-sequence with another request still queued.
    set_req(0, 9, 4, 1, 1, 17, 11, 22, 33);
    req_valid = 1'b1;
    cycle();
    set_req(0, 10, 5, 0, 0, 18, 44, 55, 66);
    cycle();
    req_valid = 1'b0;
    for (int i = 0; i < (GAP ? 4 : 2); i++) cycle();
    reset = 1'b0;
    cycle();
    chk("mid_reset_writedata", writedata, 0);
    chk("mid_reset_level", 32'(fifo_level), 0);
    reset = 1'b1;
    nz = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (writedata != 0) nz++;
    end
    chk("mid_reset_no_words", nz, 0);
    chk("final_busy", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
